// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with issue scoreboard and bulk-clear sweep
module reg_file_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clearing;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic              we0;
  logic              we1;
  logic              iss;

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic              rb [2];

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Writes and issues only land outside the sweep and never on a hardwired zero register.
  assign we0 = wr_en0   && !clearing && !is_zero_reg(wr_addr0);
  assign we1 = wr_en1   && !clearing && !is_zero_reg(wr_addr1);
  assign iss = issue_en && !clearing && !is_zero_reg(issue_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
      end else if (clr_req) begin
        clr_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (clr_req) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    clearing = (state == S_CLEAR);
  end

  assign clr_busy = clearing;

  // Port 1 is applied last so it wins a same-address collision; issue is applied
  // after the writes so a new producer keeps the register busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else if (clearing) begin
      mem[clr_cnt]  <= '0;
      busy[clr_cnt] <= 1'b0;
    end else begin
      if (we0) begin
        mem[wr_addr0]  <= wr_data0;
        busy[wr_addr0] <= 1'b0;
      end
      if (we1) begin
        mem[wr_addr1]  <= wr_data1;
        busy[wr_addr1] <= 1'b0;
      end
      if (iss) begin
        busy[issue_addr] <= 1'b1;
      end
    end
  end

  assign ra[0] = rd_addr1;
  assign ra[1] = rd_addr2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = mem[ra[p]];
      rb[p] = busy[ra[p]];
      if ((BYPASS != 0) && we0 && (wr_addr0 == ra[p])) rd[p] = wr_data0;
      if ((BYPASS != 0) && we1 && (wr_addr1 == ra[p])) rd[p] = wr_data1;
      if (clearing || is_zero_reg(ra[p])) begin
        rd[p] = '0;
        rb[p] = 1'b0;
      end
    end
  end

  assign rd_data1 = rd[0];
  assign rd_data2 = rd[1];
  assign rd_busy1 = rb[0];
  assign rd_busy2 = rb[1];

endmodule
